iob_clint_arb: RTL and testbench

//  Round-robin arbiter that shares one IOb native slave port of the CLINT timer/software-interrupt

---
 rtl/iob_clint_arb_pkg.sv | 14 +
 rtl/iob_rr_prio_enc.sv | 37 +++
 rtl/iob_clint_arb.sv | 142 ++++++++++++++
 tb/tb_iob_clint_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_clint_arb_pkg.sv
// rtl/iob_clint_arb_pkg.sv - shared state encodings and default sizes for the CLINT port arbiter
package iob_clint_arb_pkg;

    localparam int N_REQ_DEF  = 2;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/iob_rr_prio_enc.sv
// rtl/iob_rr_prio_enc.sv - round-robin priority encoder: first set request at or after ptr, wrapping
module iob_rr_prio_enc #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/iob_clint_arb.sv
// rtl/iob_clint_arb.sv - round-robin arbiter sharing one CLINT IOb slave port between N_REQ requesters
module iob_clint_arb
    import iob_clint_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          s_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]   s_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   s_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] s_wstrb_i,
    output logic [N_REQ-1:0]          s_ready_o,
    output logic [N_REQ-1:0]          s_rvalid_o,
    output logic [DATA_W-1:0]         s_rdata_o,
    output logic                      m_avalid_o,
    output logic [ADDR_W-1:0]         m_addr_o,
    output logic [DATA_W-1:0]         m_wdata_o,
    output logic [DATA_W/8-1:0]       m_wstrb_o,
    input  logic                      m_ready_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    output logic [N_REQ-1:0]          grant_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [N_REQ-1:0] enc_gnt;
    logic [PW-1:0]    enc_idx;
    logic             enc_valid;

    logic              sel_avalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SW-1:0]     sel_wstrb;

    iob_rr_prio_enc #(.N(N_REQ)) u_prio (
        .req   (s_avalid_i),
        .ptr   (ptr_q),
        .gnt   (enc_gnt),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Request mux for the current owner, selected by the latched grant index.
    always_comb begin
        sel_avalid = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_wstrb  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (gidx_q == PW'(r)) begin
                sel_avalid = s_avalid_i[r];
                sel_addr   = s_addr_i[r*ADDR_W +: ADDR_W];
                sel_wdata  = s_wdata_i[r*DATA_W +: DATA_W];
                sel_wstrb  = s_wstrb_i[r*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        m_avalid_o = 1'b0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        s_ready_o  = '0;
        s_rvalid_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    grant_d = enc_gnt;
                    gidx_d  = enc_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                m_addr_o  = sel_addr;
                m_wdata_o = sel_wdata;
                m_wstrb_o = sel_wstrb;
                if (!sel_avalid) begin
                    // Owner withdrew before accept: drop the slot, keep the pointer.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    m_avalid_o = 1'b1;
                    s_ready_o  = grant_q & {N_REQ{m_ready_i}};
                    if (m_ready_i) begin
                        ptr_d = (gidx_q == PW'(N_REQ-1)) ? '0 : gidx_q + 1'b1;
                        if (|sel_wstrb) begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (m_rvalid_i) begin
                    s_rvalid_o = grant_q;
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign s_rdata_o = m_rdata_i;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_iob_clint_arb.sv
// tb/tb_iob_clint_arb.sv - self-checking bench for iob_clint_arb with a behavioural CLINT model
module tb_iob_clint_arb;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk_i = 1'b0;
    logic            cke_i;
    logic            rst_i;
    logic [N-1:0]    s_avalid_i;
    logic [N*AW-1:0] s_addr_i;
    logic [N*DW-1:0] s_wdata_i;
    logic [N*SW-1:0] s_wstrb_i;
    logic [N-1:0]    s_ready_o;
    logic [N-1:0]    s_rvalid_o;
    logic [DW-1:0]   s_rdata_o;
    logic            m_avalid_o;
    logic [AW-1:0]   m_addr_o;
    logic [DW-1:0]   m_wdata_o;
    logic [SW-1:0]   m_wstrb_o;
    logic            m_ready_i;
    logic            m_rvalid_i;
    logic [DW-1:0]   m_rdata_i;
    logic [N-1:0]    grant_o;

    iob_clint_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk_i),
        .cke_i      (cke_i),
        .rst_i      (rst_i),
        .s_avalid_i (s_avalid_i),
        .s_addr_i   (s_addr_i),
        .s_wdata_i  (s_wdata_i),
        .s_wstrb_i  (s_wstrb_i),
        .s_ready_o  (s_ready_o),
        .s_rvalid_o (s_rvalid_o),
        .s_rdata_o  (s_rdata_o),
        .m_avalid_o (m_avalid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .grant_o    (grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            req;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] exp_rdata;
    } txn_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] clint_mem [int];
    int   rd_lat    = 1;
    int   rdy_lat   = 0;
    bit   rdy_block = 1'b0;
    int   wait_cnt  = 0;
    int   rd_cnt    = 0;
    logic [AW-1:0] rd_addr = '0;

    txn_t          req_q  [N][$];
    txn_t          cur    [N];
    bit            busy   [N];
    bit            acc_flag [N];
    logic [DW-1:0] rd_exp [N][$];
    int            acc_log [$];
    int            exp_q   [$];
    int            ready_cnt  = 0;
    int            rvalid_cnt = 0;
    int            mg;
    logic [DW-1:0] wtmp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected value 0x%0h", name, act);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return clint_mem.exists(int'(a)) ? clint_mem[int'(a)] : '0;
    endfunction

    function automatic bit tb_pending();
        bit p = (rd_cnt != 0) || (grant_o != '0);
        for (int r = 0; r < N; r++) begin
            if (busy[r] || req_q[r].size() != 0 || rd_exp[r].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    // CLINT model drives on the falling edge; the monitor samples 2 time units later.
    always @(negedge clk_i) begin
        m_rvalid_i = 1'b0;
        m_rdata_i  = $urandom;
        if (rd_cnt == 1) begin
            m_rvalid_i = 1'b1;
            m_rdata_i  = mem_rd(rd_addr);
        end
        if (rd_cnt > 0) rd_cnt--;
        if (m_avalid_o && !rdy_block && wait_cnt >= rdy_lat) begin
            m_ready_i = 1'b1;
        end else begin
            m_ready_i = 1'b0;
            if (m_avalid_o) wait_cnt++;
            else            wait_cnt = 0;
        end
        #2;
        if (!rst_i && cke_i && m_avalid_o && m_ready_i) begin
            mg = onehot_idx(s_ready_o);
            ready_cnt++;
            wait_cnt = 0;
            if (mg >= 0 && busy[mg]) begin
                check($sformatf("acc_addr_r%0d", mg), 64'(m_addr_o), 64'(cur[mg].addr));
                check($sformatf("acc_wdata_r%0d", mg), 64'(m_wdata_o), 64'(cur[mg].wdata));
                check($sformatf("acc_wstrb_r%0d", mg), 64'(m_wstrb_o), 64'(cur[mg].wstrb));
                acc_log.push_back(mg);
                acc_flag[mg] = 1'b1;
            end else begin
                flag_fail("ready_owner", 64'(s_ready_o));
            end
            if (|m_wstrb_o) begin
                wtmp = mem_rd(m_addr_o);
                for (int b = 0; b < SW; b++) begin
                    if (m_wstrb_o[b]) wtmp[b*8 +: 8] = m_wdata_o[b*8 +: 8];
                end
                clint_mem[int'(m_addr_o)] = wtmp;
            end else begin
                rd_addr = m_addr_o;
                rd_cnt  = rd_lat;
            end
        end else if (s_ready_o != '0) begin
            flag_fail("stray_ready", 64'(s_ready_o));
        end
        if (s_rvalid_o != '0) begin
            mg = onehot_idx(s_rvalid_o);
            rvalid_cnt++;
            if (mg < 0 || rd_exp[mg].size() == 0) begin
                flag_fail("stray_rvalid", 64'(s_rvalid_o));
            end else begin
                check($sformatf("rdata_r%0d", mg), 64'(s_rdata_o), 64'(rd_exp[mg].pop_front()));
            end
        end
        if (!rst_i && grant_o == '0) begin
            check("idle_m_zero", {11'd0, m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o}, 64'd0);
        end
    end

    // Requester agents: hold avalid/addr/wdata until accepted, then load the next queued request.
    always @(posedge clk_i) begin
        #1;
        for (int r = 0; r < N; r++) begin
            if (acc_flag[r]) begin
                acc_flag[r]   = 1'b0;
                busy[r]       = 1'b0;
                s_avalid_i[r] = 1'b0;
            end
            if (!busy[r] && req_q[r].size() != 0) begin
                cur[r]                  = req_q[r].pop_front();
                busy[r]                 = 1'b1;
                s_avalid_i[r]           = 1'b1;
                s_addr_i[r*AW +: AW]    = cur[r].addr;
                s_wdata_i[r*DW +: DW]   = cur[r].wdata;
                s_wstrb_i[r*SW +: SW]   = cur[r].wstrb;
            end
        end
    end

    task automatic issue(input txn_t t, input bit expect_rsp);
        req_q[t.req].push_back(t);
        if (t.wstrb == '0 && expect_rsp) rd_exp[t.req].push_back(t.exp_rdata);
    endtask

    task automatic mk(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [DW-1:0] e, input bit expect_rsp);
        txn_t t;
        t.req = r; t.addr = a; t.wdata = d; t.wstrb = s; t.exp_rdata = e;
        issue(t, expect_rsp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (tb_pending() && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_done"}, 64'(n >= 300), 64'd0);
    endtask

    task automatic check_order(input string name);
        check({name, "_len"}, 64'(acc_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            check($sformatf("%s_g%0d", name, i), 64'(acc_log[i]), 64'(exp_q[i]));
        end
        acc_log.delete();
        exp_q.delete();
    endtask

    initial begin
        txn_t vecs [6];
        int   rc0;
        int   n;

        vecs[0] = '{req: 0, addr: 16'h4000, wdata: 32'h0000_0010, wstrb: 4'hF, exp_rdata: 32'h0};
        vecs[1] = '{req: 0, addr: 16'h4000, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h0000_0010};
        vecs[2] = '{req: 1, addr: 16'h4004, wdata: 32'hAABB_CCDD, wstrb: 4'h3, exp_rdata: 32'h0};
        vecs[3] = '{req: 1, addr: 16'h4004, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'h1122_CCDD};
        vecs[4] = '{req: 3, addr: 16'hBFF8, wdata: 32'h0,         wstrb: 4'h0, exp_rdata: 32'hCAFE_0001};
        vecs[5] = '{req: 2, addr: 16'h0004, wdata: 32'h0000_0001, wstrb: 4'h1, exp_rdata: 32'h0};

        cke_i      = 1'b1;
        rst_i      = 1'b1;
        s_avalid_i = '0;
        s_addr_i   = '0;
        s_wdata_i  = '0;
        s_wstrb_i  = '0;
        m_ready_i  = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        clint_mem[32'hBFF8] = 32'hCAFE_0001;
        clint_mem[32'h0000] = 32'h0000_0003;
        clint_mem[32'h4004] = 32'h1122_3344;

        repeat (2) cyc();
        check("rst_grant",  64'(grant_o),    64'd0);
        check("rst_avalid", 64'(m_avalid_o), 64'd0);
        check("rst_ready",  64'(s_ready_o),  64'd0);
        check("rst_rvalid", 64'(s_rvalid_o), 64'd0);
        rst_i = 1'b0;
        cyc();

        // Single transactions from the vector table.
        for (int i = 0; i < 6; i++) begin
            rc0 = ready_cnt;
            issue(vecs[i], 1'b1);
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ready_pulses", i), 64'(ready_cnt - rc0), 64'd1);
            exp_q.push_back(vecs[i].req);
            check_order($sformatf("vec%0d", i));
        end

        // Simultaneous reads straight after reset: req0 first, then req1.
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        rc0 = rvalid_cnt;
        mk(0, 16'hBFF8, 32'h0, 4'h0, 32'hCAFE_0001, 1'b1);
        mk(1, 16'h0000, 32'h0, 4'h0, 32'h0000_0003, 1'b1);
        wait_done("simul");
        check("simul_rvalids", 64'(rvalid_cnt - rc0), 64'd2);
        exp_q.push_back(0);
        exp_q.push_back(1);
        check_order("simul");

        // Fairness: both requesters keep four requests queued; grants must alternate.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                mk(0, 16'h4008, 32'h100 + 32'(k), 4'hF, 32'h0, 1'b1);
                mk(1, 16'h400C, 32'h200 + 32'(k), 4'hF, 32'h0, 1'b1);
            end else begin
                mk(0, 16'h4008, 32'h0, 4'h0, 32'h100 + 32'(k - 1), 1'b1);
                mk(1, 16'h400C, 32'h0, 4'h0, 32'h200 + 32'(k - 1), 1'b1);
            end
        end
        wait_done("fair");
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 2);
        check_order("fair");

        // Pointer wrap: after serving req2, req3 beats req0.
        mk(2, 16'h4010, 32'h5, 4'hF, 32'h0, 1'b1);
        wait_done("wrap_a");
        mk(0, 16'h4014, 32'h6, 4'hF, 32'h0, 1'b1);
        mk(3, 16'h4018, 32'h7, 4'hF, 32'h0, 1'b1);
        wait_done("wrap_b");
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        check_order("wrap");

        // Reset while waiting for read data; the late rvalid must not reach the requester.
        rd_lat = 4;
        rc0    = rvalid_cnt;
        mk(2, 16'hBFF8, 32'h0, 4'h0, 32'h0, 1'b0);
        n = 0;
        while (acc_log.size() == 0 && n < 20) begin
            cyc();
            n++;
        end
        check("rstrd_accepted", 64'(acc_log.size()), 64'd1);
        cyc();
        check("rstrd_grant_rdwait", 64'(grant_o), 64'b0100);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("rstrd_grant_cleared", 64'(grant_o), 64'd0);
        wait_done("rstrd");
        check("rstrd_no_rvalid", 64'(rvalid_cnt - rc0), 64'd0);
        rd_lat = 1;
        acc_log.delete();
        mk(0, 16'h401C, 32'h8, 4'hF, 32'h0, 1'b1);
        mk(3, 16'h4020, 32'h9, 4'hF, 32'h0, 1'b1);
        wait_done("rstrd_ptr");
        exp_q.push_back(0);
        exp_q.push_back(3);
        check_order("rstrd_ptr");

        // Abort: req1 withdraws while the CLINT is stalled; pointer must stay at 1.
        mk(0, 16'h4024, 32'hA, 4'hF, 32'h0, 1'b1);
        wait_done("abort_pre");
        acc_log.delete();
        rc0       = ready_cnt;
        rdy_block = 1'b1;
        s_avalid_i[1]          = 1'b1;
        s_addr_i[1*AW +: AW]   = 16'h4028;
        s_wdata_i[1*DW +: DW]  = 32'hB;
        s_wstrb_i[1*SW +: SW]  = 4'hF;
        cyc();
        check("abort_avalid_req", 64'(m_avalid_o), 64'd1);
        check("abort_grant_req",  64'(grant_o),    64'b0010);
        check("abort_addr_req",   64'(m_addr_o),   64'h4028);
        s_avalid_i[1]          = 1'b0;
        s_wstrb_i[1*SW +: SW]  = 4'h0;
        cyc();
        check("abort_grant_idle",  64'(grant_o),    64'd0);
        check("abort_avalid_idle", 64'(m_avalid_o), 64'd0);
        check("abort_no_ready",    64'(ready_cnt - rc0), 64'd0);
        rdy_block = 1'b0;
        mk(0, 16'h402C, 32'hC, 4'hF, 32'h0, 1'b1);
        mk(1, 16'h4030, 32'hD, 4'hF, 32'h0, 1'b1);
        wait_done("abort_post");
        exp_q.push_back(1);
        exp_q.push_back(0);
        check_order("abort");

        // Clock enable low: a pending request must not be granted.
        cke_i = 1'b0;
        mk(3, 16'h4034, 32'hE, 4'hF, 32'h0, 1'b1);
        repeat (3) cyc();
        check("cke_grant_hold",  64'(grant_o),    64'd0);
        check("cke_avalid_hold", 64'(m_avalid_o), 64'd0);
        cke_i = 1'b1;
        wait_done("cke");
        exp_q.push_back(3);
        check_order("cke");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
